fac_4_dec: RTL and testbench

Streaming decoder for 9-bit shared-factor vectors of GF(2^4) elements, the inverse of the factor-sum expansion used in the masked Canright S-box datapath. Each input beat carries three 3-bit factor triples, {sum, hi, lo}. The block recovers the 4-bit element and checks every redundant bit for consistency. It sits between the shared-factor pipeline and any stage or debug port that needs plain nibbles, and flags fault-injection or wiring errors. The block is a two-stage valid/ready pipeline with a sticky error flag and a saturating error counter.

---
 rtl/fac_4_dec.sv | 107 ++++++++++
 tb/tb_fac_4_dec.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fac_4_dec.sv
`default_nettype none
// ============================================================================
//  Module   : fac_4_dec
//  Purpose  : Two-stage valid/ready decoder from 9-bit shared-factor vectors
//             to GF(2^4) nibbles, with redundancy checks and error tracking.
//  Revision : 1.0
// ============================================================================
module fac_4_dec #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_a,
    output logic             out_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_err
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic             r_s1_valid;
    logic [8:0]       r_s1_q;
    logic             r_out_valid;
    logic [3:0]       r_out_a;
    logic             r_out_err;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic             w_deliver;
    logic [1:0]       w_lo;
    logic [1:0]       w_hi;
    logic [1:0]       w_sum;
    logic [3:0]       w_chk;

    assign w_s2_adv  = ~r_out_valid | out_ready;
    assign w_s1_adv  = r_s1_valid & w_s2_adv;
    assign in_ready  = ~rst & (~r_s1_valid | w_s2_adv);
    assign w_accept  = in_valid & in_ready;
    assign w_deliver = r_out_valid & out_ready;

    // The sum triple only participates in checking, never in the decoded value.
    assign w_lo  = r_s1_q[1:0];
    assign w_hi  = r_s1_q[4:3];
    assign w_sum = r_s1_q[7:6];

    assign w_chk[0] = r_s1_q[2] != (r_s1_q[1] ^ r_s1_q[0]);
    assign w_chk[1] = r_s1_q[5] != (r_s1_q[4] ^ r_s1_q[3]);
    assign w_chk[2] = r_s1_q[8] != (r_s1_q[7] ^ r_s1_q[6]);
    assign w_chk[3] = w_sum != (w_hi ^ w_lo);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_q      <= '0;
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_err   <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_a   <= {w_hi, w_lo};
                    r_out_err <= |w_chk;
                end
            end
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_q     <= in_q;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Clear wins over a same-cycle erroneous delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else if (clr_err) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else if (w_deliver && r_out_err) begin
            r_err_sticky <= 1'b1;
            if (r_err_cnt != c_CNT_MAX) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_a      = r_out_a;
    assign out_err    = r_out_err;
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fac_4_dec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fac_4_dec
//  Purpose  : Randomized and directed bench for fac_4_dec against a beat-queue model.
//  Revision : 1.0
// ============================================================================
module tb_fac_4_dec;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic [8:0] in_q;
    logic       out_ready;
    logic       clr_err;

    logic       in_ready, out_valid, out_err, err_sticky;
    logic [3:0] out_a;
    logic [7:0] err_cnt;

    logic       in_ready_s, out_valid_s, out_err_s, err_sticky_s;
    logic [3:0] out_a_s;
    logic [1:0] err_cnt_s;

    fac_4_dec #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_err(out_err),
        .err_sticky(err_sticky), .err_cnt(err_cnt), .clr_err(clr_err)
    );

    fac_4_dec #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_q(in_q),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_a(out_a_s), .out_err(out_err_s),
        .err_sticky(err_sticky_s), .err_cnt(err_cnt_s), .clr_err(clr_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [8:0] q;
        int         acc;
    } beat_t;

    beat_t      mq[$];
    logic [8:0] pend[$];
    int         cyc = 0;
    int         m_cnt = 0;
    int         m_cnt_s = 0;
    bit         m_sticky = 0;
    bit         gate = 0;
    bit         dut_acc;

    function automatic logic [8:0] encode(input logic [3:0] a);
        logic [1:0] h, l, s;
        h = a[3:2];
        l = a[1:0];
        s = h ^ l;
        return {^s, s, ^h, h, ^l, l};
    endfunction

    function automatic bit is_bad(input logic [8:0] q);
        return q != encode({q[4:3], q[1:0]});
    endfunction

    task automatic cycle();
        bit         exp_rdy, exp_ov, acc, dlv, ferr;
        logic [8:0] fq;
        in_valid = gate && (pend.size() > 0);
        in_q     = (pend.size() > 0) ? pend[0] : 9'd0;
        @(negedge clk);
        exp_rdy = !rst && (mq.size() < 2 || out_ready);
        exp_ov  = (mq.size() > 0) && (cyc - mq[0].acc >= 2);
        fq      = (mq.size() > 0) ? mq[0].q : 9'd0;
        ferr    = is_bad(fq);
        check_val("in_ready", in_ready, exp_rdy);
        check_val("in_ready_s", in_ready_s, exp_rdy);
        check_val("out_valid", out_valid, exp_ov);
        check_val("out_valid_s", out_valid_s, exp_ov);
        if (exp_ov) begin
            check_val("out_a", out_a, {fq[4:3], fq[1:0]});
            check_val("out_err", out_err, ferr);
            check_val("out_err_s", out_err_s, ferr);
        end
        check_val("err_cnt", err_cnt, m_cnt);
        check_val("err_cnt_s", err_cnt_s, m_cnt_s);
        check_val("err_sticky", err_sticky, m_sticky);
        check_val("err_sticky_s", err_sticky_s, m_sticky);
        acc     = in_valid && exp_rdy;
        dlv     = exp_ov && out_ready;
        dut_acc = in_valid && in_ready;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_cnt    = 0;
            m_cnt_s  = 0;
            m_sticky = 0;
        end else begin
            if (dlv) void'(mq.pop_front());
            if (clr_err) begin
                m_cnt    = 0;
                m_cnt_s  = 0;
                m_sticky = 0;
            end else if (dlv && ferr) begin
                m_sticky = 1;
                if (m_cnt < 255) m_cnt++;
                if (m_cnt_s < 3) m_cnt_s++;
            end
            if (acc) begin
                mq.push_back('{q: in_q, acc: cyc});
                void'(pend.pop_front());
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((pend.size() > 0 || mq.size() > 0) && n < 100) begin
            cycle();
            n++;
        end
        if (n >= 100) check_val("drain_timeout", 1, 0);
    endtask

    function automatic logic [8:0] rand_beat();
        logic [8:0] q;
        q = encode(4'($urandom_range(15)));
        if ($urandom_range(1) == 1) q = q ^ (9'd1 << $urandom_range(8));
        return q;
    endfunction

    initial begin
        int n;
        logic [8:0] base;
        rst = 1'b1; gate = 1; out_ready = 1'b1; clr_err = 1'b0;
        in_valid = 1'b0; in_q = '0;

        // Beat offered during reset must not be taken.
        pend.push_back(encode(4'h5));
        repeat (3) cycle();
        check_val("rst_ov", out_valid, 0);
        rst = 1'b0;
        pend.delete();

        pend.push_back(9'b011_110_101);
        repeat (4) cycle();

        for (int i = 0; i < 16; i++) pend.push_back(encode(4'(i)));
        drain();
        check_val("sweep_cnt", err_cnt, 0);

        base = encode(4'($urandom_range(15)));
        for (int b = 0; b < 9; b++) pend.push_back(base ^ (9'd1 << b));
        drain();
        repeat (2) cycle();
        check_val("fault_cnt", err_cnt, 9);
        check_val("fault_sticky", err_sticky, 1);
        check_val("fault_cnt_s", err_cnt_s, 3);

        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        check_val("clr_cnt", err_cnt, 0);

        for (int i = 0; i < 5; i++) pend.push_back(encode(4'(i)) ^ 9'h100);
        drain();
        repeat (2) cycle();
        check_val("sat_cnt_s", err_cnt_s, 3);
        check_val("sat_cnt", err_cnt, 5);
        out_ready = 1'b0;
        pend.push_back(encode(4'hA) ^ 9'h001);
        repeat (3) cycle();
        out_ready = 1'b1;
        clr_err   = 1'b1;
        cycle();
        clr_err   = 1'b0;
        check_val("sat_clr_cnt_s", err_cnt_s, 0);
        check_val("sat_clr_sticky", err_sticky_s, 0);
        check_val("sat_clr_ov", out_valid, 0);
        repeat (2) cycle();

        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) pend.push_back(rand_beat());
        n = 0;
        repeat (4) begin
            cycle();
            n += int'(dut_acc);
        end
        check_val("bp_accepted", n, 2);
        check_val("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        drain();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) != 0 && pend.size() < 4) pend.push_back(rand_beat());
            gate      = $urandom_range(3) != 0;
            out_ready = $urandom_range(3) != 0;
            clr_err   = $urandom_range(63) == 0;
            cycle();
        end
        gate = 1; out_ready = 1'b1; clr_err = 1'b0;
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) pend.push_back(encode(4'(i)) ^ 9'h020);
        repeat (4) cycle();
        rst = 1'b1;
        repeat (2) cycle();
        check_val("mid_rst_ov", out_valid, 0);
        check_val("mid_rst_cnt", err_cnt, 0);
        rst = 1'b0;
        pend.delete();
        out_ready = 1'b1;
        pend.push_back(encode(4'hC));
        repeat (4) cycle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
